// File: rtl/jk_mode_reg.sv
// Multi-mode register: per-bit JK flops, modulo up/down counter or left shifter.
// Output tc flags the terminal count of the current counting direction.
module jk_mode_reg #(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc
);

  typedef enum logic [1:0] {
    ModeJk   = 2'b00,
    ModeUp   = 2'b01,
    ModeDown = 2'b10,
    ModeShl  = 2'b11
  } mode_e;

  // MODULUS may be 2**WIDTH, so only the terminal value is kept at WIDTH bits.
  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 64'd1);

  mode_e            mode_s;
  logic [WIDTH-1:0] q_q, q_d;

  assign mode_s = mode_e'(mode);

  always_comb begin
    q_d = q_q;
    if (en) begin
      unique case (mode_s)
        ModeJk:   q_d = (j & ~q_q) | (~k & q_q);
        ModeUp:   q_d = (q_q < MaxVal) ? q_q + WIDTH'(1) : '0;
        // Out-of-range values re-enter the count at the top.
        ModeDown: q_d = ((q_q == '0) || (q_q > MaxVal)) ? MaxVal : q_q - WIDTH'(1);
        ModeShl:  q_d = {q_q[WIDTH-2:0], sin};
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q    = q_q;
  assign qbar = ~q_q;
  assign tc   = ((mode_s == ModeUp) && (q_q == MaxVal)) ||
                ((mode_s == ModeDown) && (q_q == '0));

endmodule

// File: doc/jk_mode_reg.md
JK_MODE_REG -- requirements
Module: jk_mode_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the register width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MODULUS, default 16, giving the count modulus (legal range 2..2**WIDTH).
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port en  input  1  synchronous enable; when 0, q holds in every mode.
REQ-006 The block SHALL have port mode  input  2  operating mode: 00 JK, 01 count up, 10 count down, 11 shift left.
REQ-007 The block SHALL have port j  input  WIDTH  per-bit J inputs, used in mode 00 only.
REQ-008 The block SHALL have port k  input  WIDTH  per-bit K inputs, used in mode 00 only.
REQ-009 The block SHALL have port sin  input  1  serial input, used in mode 11 only.
REQ-010 The block SHALL have port q  output  WIDTH  registered state.
REQ-011 The block SHALL have port qbar  output  WIDTH  bitwise complement of q.
REQ-012 The block SHALL have port tc  output  1  terminal-count flag.

Function
REQ-013 q SHALL update only on rising clk with reset=0 and en=1; otherwise it SHALL hold.
REQ-014 mode, j, k and sin SHALL be sampled on the same edge that applies them; a mode change takes effect on that edge with no extra latency.
REQ-015 In mode 00, each bit i SHALL follow JK rules independently: j=0,k=0 hold; j=0,k=1 clear to 0; j=1,k=0 set to 1; j=1,k=1 toggle.
REQ-016 In mode 01, q SHALL become q+1 if q<MODULUS-1, and 0 if q>=MODULUS-1, including out-of-range values.
REQ-017 In mode 10, q SHALL become q-1 if 0<q<MODULUS, and MODULUS-1 if q=0 or q>=MODULUS.
REQ-018 In mode 11, q SHALL become {q[WIDTH-2:0], sin}; the MSB is discarded.
REQ-019 j and k SHALL have no effect outside mode 00, and sin SHALL have no effect outside mode 11.
REQ-020 Out-of-range values (q>=MODULUS) SHALL be reachable only through modes 00 and 11, and SHALL be retained unchanged in those modes.
REQ-021 qbar SHALL equal ~q at all times, combinationally.
REQ-022 tc SHALL be combinational: 1 when mode=01 and q=MODULUS-1, 1 when mode=10 and q=0, and 0 otherwise; tc is independent of en.
REQ-023 Count arithmetic SHALL be performed at WIDTH bits with no carry or borrow out; wrap is governed solely by REQ-016 and REQ-017.

Reset
REQ-024 Asserting reset SHALL force q=0 immediately, without waiting for clk, regardless of en, mode, j, k or sin.
REQ-025 While reset is high, q SHALL stay 0, and qbar and tc SHALL follow REQ-021 and REQ-022 from q=0 (e.g. tc=1 in mode 10).
REQ-026 After reset deasserts, the first state change SHALL occur on the first rising clk at which reset=0 and en=1.
REQ-027 Reset asserted mid-operation in any mode SHALL discard the in-progress count or shift value, with no later recovery of it.

Verification
REQ-028 The bench SHALL check JK mode: q=4'b0110, j=4'b1100, k=4'b1010, en=1, one edge -> q=4'b1100, qbar=4'b0011.
REQ-029 The bench SHALL check up-count wrap: MODULUS=10, q=0, mode=01, 10 edges -> q=1..9 then 0; tc=1 exactly while q=9.
REQ-030 The bench SHALL check down-count wrap: MODULUS=10, q=0, mode=10, one edge -> q=9; tc=1 while q=0 before that edge.
REQ-031 The bench SHALL check shift and enable: from q=0, mode=11, sin=1,0,1,1 on 4 edges -> q=4'b1011; then en=0 for 3 edges -> q stays 4'b1011.
REQ-032 The bench SHALL check out-of-range recovery: MODULUS=10, JK-set q=4'hF, then one up edge -> q=0; JK-set 4'hF again, then one down edge -> q=9.
REQ-033 The bench SHALL check asynchronous reset: q=4'hA, reset=1 midway between edges -> q=0 before the next edge; release, then one up edge -> q=1.
